// File: rtl/bfs_enq_packer.sv
// BFS frontier enqueue packer: pairs 32-bit node IDs into 64-bit queue words.
// Ports: in_* beat stream, flush/flush_done drain handshake, queue_full
// backpressure, enq_req/enq_data queue write, busy, enq_count ID total.
module bfs_enq_packer #(
    parameter int HOLD_TIMEOUT = 16,
    parameter int COUNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    output logic               in_ready,
    input  logic               flush,
    output logic               flush_done,
    input  logic               queue_full,
    output logic [1:0]         enq_req,
    output logic [63:0]        enq_data,
    output logic               busy,
    output logic [COUNT_W-1:0] enq_count
);

    localparam int TW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam bit TMO_EN = (HOLD_TIMEOUT > 0);
    localparam logic [TW-1:0] T_MAX  = TW'(HOLD_TIMEOUT);
    localparam logic [TW-1:0] T_FIRE = TMO_EN ? TW'(HOLD_TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               h_valid_q, h_valid_d;
    logic [31:0]        h_data_q, h_data_d;
    logic               o_valid_q, o_valid_d;
    logic [1:0]         o_req_q, o_req_d;
    logic [63:0]        o_data_q, o_data_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic fire;
    logic o_free;
    logic accept;

    assign fire   = o_valid_q & ~queue_full;
    // O can take a new word if empty or being drained this cycle
    assign o_free = ~o_valid_q | ~queue_full;
    assign in_ready = rst_n & (state_q == RUN) & (~h_valid_q | o_free);
    assign accept = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        h_valid_d = h_valid_q;
        h_data_d  = h_data_q;
        o_valid_d = o_valid_q;
        o_req_d   = o_req_q;
        o_data_d  = o_data_q;
        timer_d   = timer_q;
        count_d   = count_q;

        if (fire) begin
            o_valid_d = 1'b0;
            count_d   = count_q + ((o_req_q == 2'b11) ? COUNT_W'(2) : COUNT_W'(1));
        end

        if (h_valid_q && !accept && timer_q != T_MAX) begin
            timer_d = timer_q + TW'(1);
        end

        unique case (state_q)
            RUN: begin
                if (accept) begin
                    if (h_valid_q) begin
                        o_valid_d = 1'b1;
                        o_req_d   = 2'b11;
                        o_data_d  = {h_data_q, in_data};
                        h_valid_d = 1'b0;
                    end else begin
                        h_valid_d = 1'b1;
                        h_data_d  = in_data;
                        timer_d   = '0;
                    end
                end else if (TMO_EN && h_valid_q && timer_q >= T_FIRE && o_free) begin
                    // lone ID waited long enough: push it alone
                    o_valid_d = 1'b1;
                    o_req_d   = 2'b01;
                    o_data_d  = {32'h0, h_data_q};
                    h_valid_d = 1'b0;
                end
                if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (h_valid_q && o_free) begin
                    o_valid_d = 1'b1;
                    o_req_d   = 2'b01;
                    o_data_d  = {32'h0, h_data_q};
                    h_valid_d = 1'b0;
                end
                if (!h_valid_q && !o_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RUN;
            h_valid_q <= 1'b0;
            h_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_req_q   <= 2'b00;
            o_data_q  <= '0;
            timer_q   <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            h_valid_q <= h_valid_d;
            h_data_q  <= h_data_d;
            o_valid_q <= o_valid_d;
            o_req_q   <= o_req_d;
            o_data_q  <= o_data_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
        end
    end

    assign enq_req    = fire ? o_req_q : 2'b00;
    assign enq_data   = o_data_q;
    assign flush_done = (state_q == DONE);
    assign busy       = h_valid_q | o_valid_q | (state_q != RUN);
    assign enq_count  = count_q;

endmodule

// File: tb/tb_bfs_enq_packer.sv
// Bench for bfs_enq_packer: directed steps plus random stress,
// with a scoreboard of accepted IDs checked against queue decode order.
module tb_bfs_enq_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        flush;
    logic        flush_done;
    logic        queue_full;
    logic [1:0]  enq_req;
    logic [63:0] enq_data;
    logic        busy;
    logic [31:0] enq_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb[$];
    logic [31:0] mdl_cnt = 0;
    logic [31:0] acc_cnt = 0;

    bfs_enq_packer #(
        .HOLD_TIMEOUT(4),
        .COUNT_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .flush(flush),
        .flush_done(flush_done),
        .queue_full(queue_full),
        .enq_req(enq_req),
        .enq_data(enq_data),
        .busy(busy),
        .enq_count(enq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Queue-side monitor: decode each enqueue word and pop the scoreboard
    always @(negedge clk) begin
        logic [31:0] e0, e1;
        if (!rst_n) begin
            sb.delete();
            mdl_cnt = 0;
            acc_cnt = 0;
        end else begin
            chk("mon_count", enq_count, mdl_cnt);
            if (enq_req == 2'b11) begin
                if (sb.size() < 2) begin
                    chk("mon_pair_underflow", 64'(sb.size()), 64'd2);
                end else begin
                    e0 = sb.pop_front();
                    e1 = sb.pop_front();
                    chk("mon_pair_hi", enq_data[63:32], e0);
                    chk("mon_pair_lo", enq_data[31:0], e1);
                end
                mdl_cnt = mdl_cnt + 2;
            end else if (enq_req == 2'b01) begin
                if (sb.size() < 1) begin
                    chk("mon_single_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    e0 = sb.pop_front();
                    chk("mon_single_hi", enq_data[63:32], 64'h0);
                    chk("mon_single_lo", enq_data[31:0], e0);
                end
                mdl_cnt = mdl_cnt + 1;
            end else if (enq_req != 2'b00) begin
                chk("mon_req_code", enq_req, 64'h0);
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                acc_cnt = acc_cnt + 1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] nxt;
        logic        acc;
        int          guard;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        queue_full = 1'b0;

        // reset values
        mid();
        chk("rst_ready", in_ready, 0);
        tick();
        mid();
        chk("rst_req", enq_req, 0);
        chk("rst_data", enq_data, 0);
        chk("rst_fdone", flush_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", enq_count, 0);
        tick();
        rst_n = 1'b1;
        mid();
        chk("rst_ready_after", in_ready, 1);
        tick();

        // pair 0xA, 0xB
        in_valid = 1'b1;
        in_data  = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        mid();
        chk("ab_req", enq_req, 2'b11);
        chk("ab_data", enq_data, 64'h0000000A_0000000B);
        tick();
        mid();
        chk("ab_count", enq_count, 2);
        chk("ab_idle", enq_req, 0);
        tick();

        // timeout single, HOLD_TIMEOUT = 4
        in_valid = 1'b1;
        in_data  = 32'h5;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            mid();
            chk("tmo_wait", enq_req, 0);
            chk("tmo_busy", busy, 1);
            tick();
        end
        mid();
        chk("tmo_req", enq_req, 2'b01);
        chk("tmo_data", enq_data, 64'h00000000_00000005);
        tick();

        // second beat at cycle 3 pairs instead of timing out
        in_valid = 1'b1;
        in_data  = 32'h15;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_data  = 32'h16;
        tick();
        in_valid = 1'b0;
        mid();
        chk("tmo3_req", enq_req, 2'b11);
        chk("tmo3_data", enq_data, 64'h00000015_00000016);
        tick();
        for (int i = 0; i < 6; i++) begin
            mid();
            chk("tmo3_nosingle", enq_req, 0);
            tick();
        end

        // flush with a held ID
        in_valid = 1'b1;
        in_data  = 32'h7;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        mid();
        chk("fl_rdy_c2", in_ready, 0);
        tick();
        mid();
        chk("fl_req", enq_req, 2'b01);
        chk("fl_data", enq_data, 64'h7);
        chk("fl_rdy_c3", in_ready, 0);
        tick();
        mid();
        chk("fl_rdy_c4", in_ready, 0);
        chk("fl_fd_c4", flush_done, 0);
        tick();
        mid();
        chk("fl_fd_c5", flush_done, 1);
        chk("fl_rdy_c5", in_ready, 0);
        tick();
        mid();
        chk("fl_fd_c6", flush_done, 0);
        chk("fl_rdy_c6", in_ready, 1);
        tick();

        // flush on an empty packer
        flush = 1'b1;
        tick();
        flush = 1'b0;
        mid();
        chk("fe_fd_t1", flush_done, 0);
        chk("fe_busy_t1", busy, 1);
        tick();
        mid();
        chk("fe_fd_t2", flush_done, 1);
        tick();
        mid();
        chk("fe_fd_t3", flush_done, 0);
        tick();

        // backpressure with a streaming source, IDs 1..8
        queue_full = 1'b1;
        in_valid   = 1'b1;
        nxt        = 32'd1;
        for (int i = 0; i < 10; i++) begin
            in_data = nxt;
            mid();
            chk("bp_req", enq_req, 0);
            chk("bp_rdy", in_ready, 64'(i < 3));
            acc = in_valid && in_ready;
            tick();
            if (acc) nxt++;
        end
        queue_full = 1'b0;
        in_data    = nxt;
        mid();
        chk("bp_rel_req", enq_req, 2'b11);
        chk("bp_rel_data", enq_data, 64'h00000001_00000002);
        acc = in_valid && in_ready;
        tick();
        if (acc) nxt++;
        guard = 0;
        while (nxt <= 32'd8 && guard < 40) begin
            in_data = nxt;
            mid();
            acc = in_valid && in_ready;
            tick();
            if (acc) nxt++;
            guard++;
        end
        chk("bp_stream_done", nxt, 32'd9);
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            mid();
            if (!busy) break;
            tick();
        end
        chk("bp_drained", busy, 0);
        chk("bp_count", enq_count, 32'd14);
        tick();

        // reset while draining with 0x9 held
        queue_full = 1'b1;
        in_valid   = 1'b1;
        in_data    = 32'h20;
        tick();
        in_data = 32'h21;
        tick();
        in_data = 32'h9;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        mid();
        chk("md_busy", busy, 1);
        chk("md_rdy", in_ready, 0);
        chk("md_req", enq_req, 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n      = 1'b1;
        queue_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mid();
            chk("md_post_req", enq_req, 0);
            chk("md_post_fd", flush_done, 0);
            chk("md_post_busy", busy, 0);
            chk("md_post_cnt", enq_count, 0);
            tick();
        end

        // random stress
        nxt = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            in_valid   = ($urandom_range(0, 99) < 70);
            queue_full = ($urandom_range(0, 99) < 30);
            flush      = ($urandom_range(0, 99) < 2);
            in_data    = nxt;
            mid();
            acc = in_valid && in_ready;
            tick();
            if (acc) nxt++;
        end
        in_valid   = 1'b0;
        queue_full = 1'b0;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 100; k++) begin
            mid();
            if (!busy) break;
            tick();
        end
        chk("rs_idle", busy, 0);
        chk("rs_sb_empty", 64'(sb.size()), 64'd0);
        chk("rs_count", enq_count, nxt - 32'h1000);
        chk("rs_acc", enq_count, acc_cnt);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bfs_enq_packer.md
# bfs_enq_packer

BFS frontier enqueue packer, directly upstream of the main BFS frontier queue. Accepts a stream of unvisited neighbour node IDs, one 32-bit ID per beat, and pairs consecutive IDs into the queue's two-slot 64-bit enqueue word. A lone leftover ID is pushed as a single entry on hold timeout or on an explicit level-end flush. Output is throttled by the queue's full flag, so no ID is ever dropped.

## Interface
- HOLD_TIMEOUT, 16: cycles an unpaired ID may wait before it is pushed alone; 0 disables the timeout (flush only).
- COUNT_W, 32: width of the enqueued-ID counter.

- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  node ID beat valid
- in_data  in  32  node ID
- in_ready  out  1  beat accepted when in_valid & in_ready
- flush  in  1  level-end request: drain the held ID and output register
- flush_done  out  1  one-cycle pulse when the drain completes
- queue_full  in  1  main queue full flag
- enq_req  out  2  enqueue request to the queue; 2'b11 = pair, 2'b01 = single, 2'b00 = idle
- enq_data  out  64  pair: first ID in [63:32], second ID in [31:0]; single: ID in [31:0], [63:32] = 0
- busy  out  1  h_valid | o_valid | state != RUN
- enq_count  out  COUNT_W  total IDs enqueued since reset (+2 per pair, +1 per single); wraps

## Operation
- **Storage**
  - Hold register H: one ID plus h_valid.
  - Output register O: 64-bit data, 2-bit req, o_valid.
  - Hold timer: width $clog2(HOLD_TIMEOUT+1).
- **Fire**
  - O fires when o_valid & ~queue_full.
  - enq_req = fire ? o_req : 2'b00.
  - enq_data = o_data whenever o_valid; value otherwise is don't-care.
  - O clears on fire unless it is reloaded in the same cycle.
  - Define o_free = ~o_valid | ~queue_full.
- **Encoding (fixed by the queue):** a single must use 2'b01 in the low half. 2'b10 is never driven.
- **FSM states: RUN, DRAIN, DONE.**
- **in_ready** = (state == RUN) & (~h_valid | o_free). It is 0 while rst_n is low.
- **Accepted beat in RUN**
  - H empty: H <= in_data; timer <= 0.
  - H full: O <= {H, in_data}, req 2'b11; H cleared.
- **Timeout** (HOLD_TIMEOUT > 0, RUN only)
  - Timer increments each cycle H is valid and no beat is accepted; it saturates at HOLD_TIMEOUT.
  - When timer >= HOLD_TIMEOUT-1, no beat is accepted, and o_free: O <= {32'h0, H}, req 2'b01; H cleared.
  - If a beat is accepted in the same cycle, the pairing wins and no single is emitted.
- **Transitions**
  - RUN → DRAIN: flush sampled high. A beat accepted in that same cycle is included in the drain.
  - DRAIN: in_ready = 0. If h_valid & o_free, push H as a single.
  - DRAIN → DONE: ~h_valid & ~o_valid.
  - DONE: flush_done = 1 for one cycle, then → RUN.
  - flush is ignored in DRAIN and DONE.
- **Counter:** enq_count adds 2 or 1 on each fire.
- **Reset:** rst_n low for one edge gives RUN, h_valid = 0, o_valid = 0, timer = 0, enq_count = 0. Any held ID is discarded, including mid-drain.

## Timing
- **Reset values:** in_ready 0 during reset and 1 the first cycle after; enq_req 2'b00; enq_data 0; flush_done 0; busy 0; enq_count 0.
- **Pair latency:** second beat accepted in cycle T → enq_req = 2'b11 in T+1 (if ~queue_full).
- **Full throughput:** one beat per cycle, one pair enqueue every 2 cycles, no bubbles while ~queue_full.
- **Timeout latency:** single beat in cycle 0 with no further beats → single O loaded at end of cycle HOLD_TIMEOUT → enq_req = 2'b01 in cycle HOLD_TIMEOUT+1.
- **Flush latency:**
  - Flush in cycle T with the packer empty → flush_done in T+2.
  - Otherwise flush_done asserts no earlier than 1 cycle after the last fire.
- **queue_full high:** O holds with enq_req = 2'b00. in_ready drops only when H and O are both full.

## Test plan
- **Reset:** reset, then beats 0xA, 0xB in consecutive cycles → enq_req = 2'b11, enq_data = 0x0000000A_0000000B one cycle after 0xB; enq_count = 2.
- **Timeout:** HOLD_TIMEOUT = 4, single beat 0x5 at cycle 0 → enq_req = 2'b01, enq_data = 0x00000000_00000005 at cycle 5. A second beat at cycle 3 instead produces a pair and no single.
- **Flush with a held ID:** beat 0x7 then flush next cycle → single 0x7 enqueued, flush_done pulses once, in_ready = 0 during drain. Flush on an empty packer → flush_done 2 cycles after flush.
- **Backpressure:** queue_full high for 10 cycles with a streaming source → enq_req = 2'b00 throughout, in_ready = 0 once H and O are full. After release, IDs 1..8 emerge as pairs (1,2)…(7,8) in order with no loss or duplication.
- **Reset mid-drain:** rst_n low while in DRAIN with H holding 0x9 → no enqueue of 0x9, flush_done never pulses, busy = 0, enq_count = 0.
- **Random stress:** random in_valid, queue_full and flush (≥10k cycles) → the scoreboarded ID sequence reconstructed from the queue's decode order (addr0 before addr1) matches input order; enq_count equals the number of IDs accepted.
